// File: rtl/pad_mux_ctrl.sv
// Pad-side IO controller: per-pad function select with break-before-make
// switching, 2-flop input synchroniser, optional debounce filter, edge
// detection into a write-1-to-clear interrupt status register, and a small
// word-addressed configuration port.
module pad_mux_ctrl #(
    parameter int unsigned NumPads = 20,
    parameter int unsigned NumFunc = 4,
    parameter logic        IdleIn  = 1'b1,
    parameter int unsigned AddrW   = 6
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       cfg_req_i,
    input  logic                       cfg_we_i,
    input  logic [AddrW-1:0]           cfg_addr_i,
    input  logic [31:0]                cfg_wdata_i,
    output logic [31:0]                cfg_rdata_o,
    output logic                       cfg_rvalid_o,
    input  logic [NumFunc*NumPads-1:0] func_o_i,
    input  logic [NumFunc*NumPads-1:0] func_oe_i,
    output logic [NumFunc*NumPads-1:0] func_i_o,
    output logic [NumPads-1:0]         pad_o,
    output logic [NumPads-1:0]         pad_oe_o,
    input  logic [NumPads-1:0]         pad_i,
    output logic                       irq_o
);

    localparam int unsigned FuncW = (NumFunc > 1) ? $clog2(NumFunc) : 1;

    logic              wr_acc;
    logic              rd_acc;
    logic              stat_wr;
    logic [NumPads-1:0] sync2_v;
    logic [NumPads-1:0] stat_v;
    logic [31:0]       rd_chain [NumPads+1];
    logic [31:0]       rdata_d;
    logic [31:0]       rdata_q;
    logic              rvalid_q;
    logic              irq_q;
    logic              unused_wdata;

    assign wr_acc   = cfg_req_i & cfg_we_i;
    assign rd_acc   = cfg_req_i & ~cfg_we_i;
    assign stat_wr  = wr_acc & (cfg_addr_i == AddrW'(NumPads));
    assign rd_chain[0] = 32'd0;

    // Only a subset of the write-data bits is stored in any register.
    assign unused_wdata = ^cfg_wdata_i;

    for (genvar gi = 0; gi < NumPads; gi++) begin : g_pad
        logic             cfg_wr;
        logic [FuncW-1:0] sel_q;
        logic             deb_en_q;
        logic [7:0]       deb_thr_q;
        logic             rise_ie_q;
        logic             fall_ie_q;
        logic             sw_hold_q;
        logic             sync1_q;
        logic             sync2_q;
        logic             filt_q;
        logic             filt_d;
        logic             prev_q;
        logic [7:0]       cnt_q;
        logic [7:0]       cnt_d;
        logic             stat_q;
        logic             stat_d;
        logic [NumFunc-1:0] o_cand;
        logic [NumFunc-1:0] oe_cand;
        logic [31:0]      cfg_word;

        assign cfg_wr = wr_acc & (cfg_addr_i == AddrW'(gi));

        // Per-pad configuration; a changed sel opens a one-cycle output gap.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                sel_q     <= '0;
                deb_en_q  <= 1'b0;
                deb_thr_q <= 8'd0;
                rise_ie_q <= 1'b0;
                fall_ie_q <= 1'b0;
                sw_hold_q <= 1'b0;
            end else begin
                sw_hold_q <= cfg_wr && (cfg_wdata_i[FuncW-1:0] != sel_q);
                if (cfg_wr) begin
                    sel_q     <= cfg_wdata_i[FuncW-1:0];
                    deb_en_q  <= cfg_wdata_i[8];
                    deb_thr_q <= cfg_wdata_i[23:16];
                    rise_ie_q <= cfg_wdata_i[24];
                    fall_ie_q <= cfg_wdata_i[25];
                end
            end
        end

        // Debounce: a disagreement with filt must last deb_thr+1 cycles.
        always_comb begin
            filt_d = filt_q;
            cnt_d  = cnt_q;
            if (!deb_en_q) begin
                filt_d = sync2_q;
                cnt_d  = 8'd0;
            end else if (sync2_q == filt_q) begin
                cnt_d = 8'd0;
            end else if (cnt_q == deb_thr_q) begin
                filt_d = sync2_q;
                cnt_d  = 8'd0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
            if (cfg_wr) begin
                cnt_d = 8'd0;
            end
        end

        // A new edge always wins over a simultaneous write-1-to-clear.
        assign stat_d = (filt_q & ~prev_q & rise_ie_q)
                      | (~filt_q & prev_q & fall_ie_q)
                      | (stat_q & ~(stat_wr & cfg_wdata_i[gi]));

        // Input path: synchroniser, filter, edge history and status bit.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                sync1_q <= IdleIn;
                sync2_q <= IdleIn;
                filt_q  <= IdleIn;
                prev_q  <= IdleIn;
                cnt_q   <= 8'd0;
                stat_q  <= 1'b0;
            end else begin
                sync1_q <= pad_i[gi];
                sync2_q <= sync1_q;
                filt_q  <= filt_d;
                prev_q  <= filt_q;
                cnt_q   <= cnt_d;
                stat_q  <= stat_d;
            end
        end

        // Routing per function; a sel >= NumFunc matches no function.
        for (genvar fi = 0; fi < NumFunc; fi++) begin : g_func
            assign o_cand[fi]  = (32'(sel_q) == fi) & func_o_i[fi*NumPads+gi];
            assign oe_cand[fi] = (32'(sel_q) == fi) & func_oe_i[fi*NumPads+gi];
            assign func_i_o[fi*NumPads+gi] = (32'(sel_q) == fi) ? filt_q : IdleIn;
        end

        assign pad_o[gi]    = (|o_cand) & ~sw_hold_q;
        assign pad_oe_o[gi] = (|oe_cand) & ~sw_hold_q;

        assign cfg_word = {6'd0, fall_ie_q, rise_ie_q, deb_thr_q, 7'd0, deb_en_q, 8'(sel_q)};
        assign rd_chain[gi+1] = rd_chain[gi]
                              | ((cfg_addr_i == AddrW'(gi)) ? cfg_word : 32'd0);
        assign sync2_v[gi] = sync2_q;
        assign stat_v[gi]  = stat_q;
    end

    // Read data selection; writes and unmapped addresses return zero.
    always_comb begin
        rdata_d = 32'd0;
        if (rd_acc) begin
            if (cfg_addr_i == AddrW'(NumPads)) begin
                rdata_d = 32'(stat_v);
            end else if (cfg_addr_i == AddrW'(NumPads + 1)) begin
                rdata_d = 32'(sync2_v);
            end else begin
                rdata_d = rd_chain[NumPads];
            end
        end
    end

    // Registered response and interrupt output.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
            irq_q    <= 1'b0;
        end else begin
            rvalid_q <= cfg_req_i;
            rdata_q  <= rdata_d;
            irq_q    <= |stat_v;
        end
    end

    assign cfg_rvalid_o = rvalid_q;
    assign cfg_rdata_o  = rdata_q;
    assign irq_o        = irq_q;

endmodule

// File: tb/tb_pad_mux_ctrl.sv
// Testbench for pad_mux_ctrl: directed scenarios followed by random traffic,
// all outputs compared every cycle against a behavioural model.
module tb_pad_mux_ctrl;

    localparam int NP = 20;
    localparam int NF = 4;
    localparam int AW = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_req;
    logic             cfg_we;
    logic [AW-1:0]    cfg_addr;
    logic [31:0]      cfg_wdata;
    logic [31:0]      cfg_rdata;
    logic             cfg_rvalid;
    logic [NF*NP-1:0] func_o;
    logic [NF*NP-1:0] func_oe;
    logic [NF*NP-1:0] func_i;
    logic [NP-1:0]    pad_o;
    logic [NP-1:0]    pad_oe;
    logic [NP-1:0]    pad_i;
    logic             irq;

    int checks = 0;
    int errors = 0;

    pad_mux_ctrl #(
        .NumPads(NP),
        .NumFunc(NF),
        .IdleIn (1'b1),
        .AddrW  (AW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cfg_req_i   (cfg_req),
        .cfg_we_i    (cfg_we),
        .cfg_addr_i  (cfg_addr),
        .cfg_wdata_i (cfg_wdata),
        .cfg_rdata_o (cfg_rdata),
        .cfg_rvalid_o(cfg_rvalid),
        .func_o_i    (func_o),
        .func_oe_i   (func_oe),
        .func_i_o    (func_i),
        .pad_o       (pad_o),
        .pad_oe_o    (pad_oe),
        .pad_i       (pad_i),
        .irq_o       (irq)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int  m_sel  [NP];
    bit  m_deb  [NP];
    int  m_thr  [NP];
    bit  m_rie  [NP];
    bit  m_fie  [NP];
    bit  m_seen1[NP];   // pad_i as captured one edge ago
    bit  m_seen2[NP];   // pad_i as captured two edges ago (synchronised view)
    bit  m_filt [NP];
    bit  m_prev [NP];
    int  m_run  [NP];   // cycles the synchronised input has disagreed with filt
    bit  m_hold [NP];
    bit  m_stat [NP];
    bit  m_irq;
    bit  m_rv;
    logic [31:0] m_rd;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_reset();
        for (int p = 0; p < NP; p++) begin
            m_sel[p] = 0; m_deb[p] = 0; m_thr[p] = 0; m_rie[p] = 0; m_fie[p] = 0;
            m_seen1[p] = 1; m_seen2[p] = 1; m_filt[p] = 1; m_prev[p] = 1;
            m_run[p] = 0; m_hold[p] = 0; m_stat[p] = 0;
        end
        m_irq = 0; m_rv = 0; m_rd = 32'd0;
    endfunction

    function automatic logic [31:0] m_cfg_word(int p);
        logic [31:0] w;
        w = 32'(m_sel[p]);
        w[8] = m_deb[p];
        w[23:16] = 8'(m_thr[p]);
        w[24] = m_rie[p];
        w[25] = m_fie[p];
        return w;
    endfunction

    // One rising clock edge, applied with the inputs the DUT sampled.
    function automatic void m_edge();
        bit any_old;
        int a;
        logic [31:0] rd;
        any_old = 0;
        rd = 32'd0;
        a = int'(cfg_addr);
        for (int p = 0; p < NP; p++) any_old |= m_stat[p];
        if (cfg_req && !cfg_we) begin
            if (a < NP) rd = m_cfg_word(a);
            else if (a == NP) for (int p = 0; p < NP; p++) rd[p] = m_stat[p];
            else if (a == NP + 1) for (int p = 0; p < NP; p++) rd[p] = m_seen2[p];
        end
        for (int p = 0; p < NP; p++) begin
            bit s, nf, rise, fall, set, clr, wr_me;
            int nrun;
            s = m_seen2[p];
            nf = m_filt[p];
            nrun = 0;
            if (!m_deb[p] || s == m_filt[p]) begin
                nf = s;
            end else if (m_run[p] + 1 >= m_thr[p] + 1) begin
                nf = s;    // disagreement has lasted thr+1 cycles
            end else begin
                nrun = m_run[p] + 1;
            end
            rise = m_filt[p] && !m_prev[p];
            fall = !m_filt[p] && m_prev[p];
            set = (rise && m_rie[p]) || (fall && m_fie[p]);
            clr = cfg_req && cfg_we && (a == NP) && cfg_wdata[p];
            wr_me = cfg_req && cfg_we && (a == p);
            m_stat[p] = set || (m_stat[p] && !clr);
            m_hold[p] = wr_me && (int'(cfg_wdata[1:0]) != m_sel[p]);
            if (wr_me) begin
                m_sel[p] = int'(cfg_wdata[1:0]);
                m_deb[p] = cfg_wdata[8];
                m_thr[p] = int'(cfg_wdata[23:16]);
                m_rie[p] = cfg_wdata[24];
                m_fie[p] = cfg_wdata[25];
                nrun = 0;
            end
            m_prev[p] = m_filt[p];
            m_filt[p] = nf;
            m_run[p] = nrun;
            m_seen2[p] = m_seen1[p];
            m_seen1[p] = pad_i[p];
        end
        m_irq = any_old;
        m_rv = cfg_req;
        m_rd = rd;
    endfunction

    task automatic check_all();
        logic [NP-1:0]    e_o, e_oe;
        logic [NF*NP-1:0] e_fi;
        for (int p = 0; p < NP; p++) begin
            e_o[p] = 1'b0;
            e_oe[p] = 1'b0;
            if (!m_hold[p] && m_sel[p] < NF) begin
                e_o[p]  = func_o[m_sel[p]*NP + p];
                e_oe[p] = func_oe[m_sel[p]*NP + p];
            end
            for (int f = 0; f < NF; f++) e_fi[f*NP + p] = (m_sel[p] == f) ? m_filt[p] : 1'b1;
        end
        check_val("pad_o",      128'(pad_o),      128'(e_o));
        check_val("pad_oe_o",   128'(pad_oe),     128'(e_oe));
        check_val("func_i_o",   128'(func_i),     128'(e_fi));
        check_val("irq_o",      128'(irq),        128'(m_irq));
        check_val("cfg_rvalid", 128'(cfg_rvalid), 128'(m_rv));
        check_val("cfg_rdata",  128'(cfg_rdata),  128'(m_rd));
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst_n) m_edge();
        #1;
        check_all();
    endtask

    task automatic cfg_wr(input int a, input logic [31:0] d);
        cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = AW'(a); cfg_wdata = d;
        cyc();
        cfg_req = 1'b0; cfg_we = 1'b0;
        $display("cfg write addr=%0d data=%08h", a, d);
    endtask

    task automatic cfg_rd(input int a, output logic [31:0] d);
        cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = AW'(a); cfg_wdata = 32'd0;
        cyc();
        d = cfg_rdata;
        cfg_req = 1'b0;
        $display("cfg read  addr=%0d data=%08h", a, d);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        logic [95:0] r;
        rst_n = 1'b0; cfg_req = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        func_o = '0; func_oe = '0; pad_i = '1;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        check_val("rst_pad_oe", 128'(pad_oe), 128'(0));
        check_val("rst_irq", 128'(irq), 128'(0));
        rst_n = 1'b1;
        repeat (3) cyc();

        cfg_rd(NP + 1, d);
        check_val("raw_in_all_ones", 128'(d), 128'(32'h000F_FFFF));
        cfg_rd(0, d);
        check_val("cfg0_reset", 128'(d), 128'(0));

        // function 2 on pad 3, break-before-make
        func_oe[2*NP + 3] = 1'b1;
        func_o[2*NP + 3] = 1'b1;
        cfg_wr(3, 32'd2);
        check_val("bbm_gap_oe", 128'(pad_oe[3]), 128'(0));
        cyc();
        check_val("bbm_new_oe", 128'(pad_oe[3]), 128'(1));
        check_val("bbm_new_o", 128'(pad_o[3]), 128'(1));
        check_val("idle_in_f0", 128'(func_i[0*NP + 3]), 128'(1));
        pad_i[3] = 1'b0;
        repeat (3) cyc();
        check_val("route_f2_low", 128'(func_i[2*NP + 3]), 128'(0));
        pad_i[3] = 1'b1;
        repeat (3) cyc();
        cfg_wr(3, 32'd2);
        check_val("same_sel_no_gap", 128'(pad_oe[3]), 128'(1));

        // debounce on pad 5, threshold 4
        cfg_wr(5, 32'h0004_0100);
        pad_i[5] = 1'b0;
        repeat (4) cyc();
        pad_i[5] = 1'b1;
        repeat (8) cyc();
        check_val("deb_glitch_kept", 128'(func_i[5]), 128'(1));
        pad_i[5] = 1'b0;
        repeat (2) cyc();
        repeat (4) cyc();
        check_val("deb_before_thr", 128'(func_i[5]), 128'(1));
        cyc();
        check_val("deb_after_thr", 128'(func_i[5]), 128'(0));

        // falling-edge interrupt on pad 7
        cfg_wr(7, 32'h0200_0000);
        pad_i[7] = 1'b0;
        repeat (4) cyc();
        check_val("irq_lat4", 128'(irq), 128'(0));
        cyc();
        check_val("irq_lat5", 128'(irq), 128'(1));
        cfg_rd(NP, d);
        check_val("stat_fall7", 128'(d), 128'(32'h80));
        cfg_wr(NP, 32'h80);
        check_val("irq_after_w1c_edge", 128'(irq), 128'(1));
        cyc();
        check_val("irq_cleared", 128'(irq), 128'(0));
        pad_i[7] = 1'b1;
        repeat (8) cyc();
        check_val("rise_masked_irq", 128'(irq), 128'(0));
        cfg_rd(NP, d);
        check_val("rise_masked_stat", 128'(d), 128'(0));

        // W1C coincident with a new falling edge: set wins
        pad_i[7] = 1'b0;
        repeat (3) cyc();
        cfg_wr(NP, 32'h80);
        cyc();
        check_val("set_beats_clr_irq", 128'(irq), 128'(1));
        cfg_rd(NP, d);
        check_val("set_beats_clr_stat", 128'(d[7]), 128'(1));

        cfg_rd(NP + 5, d);
        check_val("bad_addr_rvalid", 128'(cfg_rvalid), 128'(1));
        check_val("bad_addr_rdata", 128'(d), 128'(0));

        // asynchronous reset while pad 5 is mid-debounce
        pad_i[5] = 1'b1;
        repeat (3) cyc();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("async_rst_oe", 128'(pad_oe), 128'(0));
        check_val("async_rst_irq", 128'(irq), 128'(0));
        m_reset();
        repeat (2) cyc();
        rst_n = 1'b1;
        cfg_rd(3, d);
        check_val("cfg3_after_rst", 128'(d), 128'(0));
        cfg_rd(7, d);
        check_val("cfg7_after_rst", 128'(d), 128'(0));

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            for (int p = 0; p < NP; p++) if ($urandom_range(7) == 0) pad_i[p] = ~pad_i[p];
            r = {$urandom, $urandom, $urandom};
            func_o = r[NF*NP-1:0];
            r = {$urandom, $urandom, $urandom};
            func_oe = r[NF*NP-1:0];
            if ($urandom_range(4) == 0) begin
                int a;
                a = $urandom_range(NP + 3);
                cfg_req = 1'b1;
                cfg_we = 1'($urandom_range(1));
                cfg_addr = AW'(a);
                cfg_wdata = $urandom;
                cfg_wdata[23:16] = 8'($urandom_range(6));
                cyc();
                $display("rnd cfg we=%0d addr=%0d wdata=%08h rdata=%08h", cfg_we, a, cfg_wdata, cfg_rdata);
                cfg_req = 1'b0;
            end else begin
                cyc();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
